regfile_dump_ctrl: RTL

REGFILE_DUMP_CTRL -- requirements
Module: regfile_dump_ctrl

---
 rtl/regfile_dump_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/regfile_dump_ctrl.sv
// Debug register-file dump controller: stalls the CPU, walks the register
// indices FIRST_REG..LAST_REG through the async read port and streams each value out.
module regfile_dump_ctrl #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        halt_req,
  input  logic        halt_ack,
  output logic [4:0]  dbg_rs,
  input  logic [31:0] dbg_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_idx,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    READ,
    SEND,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [4:0] index;
  logic       load_first;
  logic       capture;
  logic       advance;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // abort takes priority over every other transition except the DONE pulse
  always_comb begin
    state_nxt  = state;
    load_first = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    halt_req   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && !abort) begin
          state_nxt  = HALT;
          load_first = 1'b1;
        end
      end
      HALT: begin
        halt_req = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (halt_ack) begin
          state_nxt = READ;
        end
      end
      READ: begin
        halt_req = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          capture   = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        halt_req  = 1'b1;
        out_valid = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (out_ready) begin
          if (out_last) begin
            state_nxt = DONE;
          end else begin
            advance   = 1'b1;
            state_nxt = READ;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // index saturates at LAST_REG so a LAST_REG of 31 never wraps back to x0
  always_ff @(posedge clk) begin
    if (reset) begin
      index    <= FIRST_IDX;
      out_data <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
    end else begin
      if (load_first) begin
        index <= FIRST_IDX;
      end else if (advance && (index != LAST_IDX)) begin
        index <= index + 5'd1;
      end
      if (capture) begin
        out_data <= dbg_rdata;
        out_idx  <= index;
        out_last <= (index == LAST_IDX);
      end
    end
  end

  assign dbg_rs = index;

endmodule
